// File: rtl/bus_pkg.sv
// Shared bus definitions: state encoding, widths and the captured-request record.
// Responder blocks import this package alongside the master.
package bus_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_T1   = 3'd1;
    localparam logic [2:0] ST_T2   = 3'd2;
    localparam logic [2:0] ST_T3   = 3'd3;
    localparam logic [2:0] ST_TW   = 3'd4;
    localparam logic [2:0] ST_T4   = 3'd5;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        T1   = ST_T1,
        T2   = ST_T2,
        T3   = ST_T3,
        TW   = ST_TW,
        T4   = ST_T4
    } bus_state_e;

    typedef struct packed {
        logic              write;
        logic              mem;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/bus_wait_counter.sv
// Counts wait states of one bus cycle; tc marks the MAX_WAIT-th wait state.
module bus_wait_counter #(
    parameter int MAX_WAIT = 15
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [7:0] count;

    // count equals the number of TW cycles entered so far in this bus cycle
    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign tc = (count == 8'(MAX_WAIT));

endmodule

// File: rtl/bus_cycle_master.sv
// Single-request bus cycle master: T1 address, T2/T3/TW strobe, T4 completion.
// All bus outputs are decoded from the state register and the captured request.
module bus_cycle_master
    import bus_pkg::*;
#(
    parameter int   MAX_WAIT = 15,
    parameter logic IOM_MEM  = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_mem,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ALE,
    output logic              CS,
    output logic [ADDR_W-1:0] Address,
    output logic              IOM,
    output logic              RD,
    output logic              WR,
    input  logic              READY,
    inout  wire logic [DATA_W-1:0] Data
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    bus_req_t   cap;
    logic       wait_tc;
    logic       in_strobe;
    logic       drive_data;
    logic       to_t4;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid) state_nxt = ST_T1;
            ST_T1:   state_nxt = ST_T2;
            ST_T2:   state_nxt = ST_T3;
            ST_T3:   state_nxt = READY ? ST_T4 : ST_TW;
            ST_TW:   if (READY || wait_tc) state_nxt = ST_T4;
            ST_T4:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign to_t4 = ((state == ST_T3) || (state == ST_TW)) && (state_nxt == ST_T4);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            // READY low here can only mean the wait budget ran out
            if (to_t4) begin
                rsp_err <= !READY;
                if (!cap.write) begin
                    rsp_rdata <= READY ? Data : 8'h00;
                end
            end
        end
    end

    // Request fields are only consulted outside IDLE, so they need no reset
    always_ff @(posedge CLK) begin
        if (state == ST_IDLE && req_valid) begin
            cap <= '{write: req_write, mem: req_mem, addr: req_addr, wdata: req_wdata};
        end
    end

    bus_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .CLK    (CLK),
        .RESET  (RESET),
        .clear  (state == ST_IDLE),
        .enable (state_nxt == ST_TW),
        .tc     (wait_tc)
    );

    assign in_strobe  = (state == ST_T2) || (state == ST_T3) || (state == ST_TW);
    assign drive_data = cap.write && (in_strobe || (state == ST_T4));

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_T4);
    assign ALE       = (state == ST_T1);
    assign CS        = (state != ST_IDLE);
    assign Address   = CS ? cap.addr : '0;
    assign IOM       = CS ? (cap.mem ? IOM_MEM : ~IOM_MEM) : 1'b0;
    assign RD        = !(in_strobe && !cap.write);
    assign WR        = !(in_strobe && cap.write);
    assign Data      = drive_data ? cap.wdata : 'z;

endmodule

// File: tb/tb_bus_cycle_master.sv
// Randomized bench for bus_cycle_master against a transaction-level phase model.
module tb_bus_cycle_master;

    localparam int   MAX_WAIT = 15;
    localparam logic IOM_MEM  = 1'b1;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_mem;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        ALE;
    logic        CS;
    logic [19:0] Address;
    logic        IOM;
    logic        RD;
    logic        WR;
    logic        READY;
    wire  [7:0]  Data;

    logic        tb_drive;
    logic [7:0]  tb_val;
    logic [7:0]  exp_rdata;
    logic        exp_err;
    int          checks   = 0;
    int          failures = 0;
    int          txn_no   = 0;

    assign Data = tb_drive ? tb_val : 8'bz;

    always #5 CLK = ~CLK;

    bus_cycle_master #(
        .MAX_WAIT (MAX_WAIT),
        .IOM_MEM  (IOM_MEM)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_mem   (req_mem),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ALE       (ALE),
        .CS        (CS),
        .Address   (Address),
        .IOM       (IOM),
        .RD        (RD),
        .WR        (WR),
        .READY     (READY),
        .Data      (Data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s txn=%0d got=%0h exp=%0h", tag, txn_no, got, exp);
        end
    endtask

    task automatic check_idle();
        check("idle_ready", req_ready, 1'b1);
        check("idle_cs", CS, 1'b0);
        check("idle_ale", ALE, 1'b0);
        check("idle_rd", RD, 1'b1);
        check("idle_wr", WR, 1'b1);
        check("idle_rsp_valid", rsp_valid, 1'b0);
        check("idle_addr", Address, 20'h0);
        check("idle_iom", IOM, 1'b0);
        check("idle_data_z", Data, tb_val);
        check("idle_rdata", rsp_rdata, exp_rdata);
        check("idle_err", rsp_err, exp_err);
    endtask

    task automatic scramble_req(input logic keep_valid);
        req_valid = keep_valid;
        req_write = 1'($urandom);
        req_mem   = 1'($urandom);
        req_addr  = 20'($urandom);
        req_wdata = 8'($urandom);
    endtask

    // Entered and left at #1 after a rising edge with the DUT idle.
    // waits = cycles READY stays low starting at T3.
    task automatic do_txn(input logic wr, input logic mem, input logic [19:0] addr,
                          input logic [7:0] wd, input int waits, input logic [7:0] rd,
                          input logic keep_valid);
        logic tmo;
        int   nw;
        int   last;
        logic iom_exp;
        tmo     = (waits > MAX_WAIT);
        nw      = tmo ? MAX_WAIT : waits;
        last    = 4 + nw;
        iom_exp = mem ? IOM_MEM : ~IOM_MEM;
        txn_no++;

        req_valid = 1'b1;
        req_write = wr;
        req_mem   = mem;
        req_addr  = addr;
        req_wdata = wd;
        READY     = 1'($urandom);
        tb_drive  = 1'b1;
        tb_val    = 8'($urandom);
        @(negedge CLK);
        check_idle();
        @(posedge CLK);
        #1;

        for (int k = 1; k <= last; k++) begin
            logic strobe;
            scramble_req(keep_valid);
            if (k >= 3 && k <= 3 + nw) READY = ((k - 3) >= waits);
            else                       READY = 1'($urandom);
            tb_drive = !(wr && k >= 2);
            tb_val   = (!wr && !tmo && k == 3 + nw) ? rd : 8'($urandom);
            strobe   = (k >= 2 && k < last);
            @(negedge CLK);
            if (k == last) begin
                exp_err = tmo;
                if (!wr) exp_rdata = tmo ? 8'h00 : rd;
            end
            check("ale", ALE, (k == 1));
            check("cs", CS, 1'b1);
            check("ready_busy", req_ready, 1'b0);
            check("addr", Address, addr);
            check("iom", IOM, iom_exp);
            check("rd", RD, !(strobe && !wr));
            check("wr", WR, !(strobe && wr));
            check("rsp_valid", rsp_valid, (k == last));
            check("data", Data, (wr && k >= 2) ? wd : tb_val);
            check("rsp_err", rsp_err, exp_err);
            check("rsp_rdata", rsp_rdata, exp_rdata);
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog txn=%0d", txn_no);
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_mem   = 1'b0;
        req_addr  = 20'h0;
        req_wdata = 8'h0;
        READY     = 1'b1;
        tb_drive  = 1'b1;
        tb_val    = 8'h5A;
        exp_rdata = 8'h00;
        exp_err   = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_idle();
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // memory write, I/O read, read with waits, timeout
        do_txn(1'b1, 1'b1, 20'h01C05, 8'hA5, 0, 8'h00, 1'b0);
        do_txn(1'b0, 1'b0, 20'h00D10, 8'h00, 0, 8'h3C, 1'b0);
        do_txn(1'b0, 1'b1, 20'hABCDE, 8'h00, 3, 8'hC3, 1'b0);
        do_txn(1'b0, 1'b1, 20'h00042, 8'h00, 40, 8'h99, 1'b0);
        do_txn(1'b0, 1'b0, 20'h00777, 8'h00, MAX_WAIT, 8'h81, 1'b0);
        do_txn(1'b1, 1'b0, 20'h00300, 8'h6E, MAX_WAIT + 1, 8'h00, 1'b0);

        // reset during T2 of a write aborts the cycle
        txn_no++;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_mem   = 1'b1;
        req_addr  = 20'h12345;
        req_wdata = 8'h77;
        READY     = 1'b1;
        tb_drive  = 1'b1;
        tb_val    = 8'($urandom);
        @(negedge CLK);
        check_idle();
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        @(posedge CLK);
        #1;
        tb_drive = 1'b0;
        @(negedge CLK);
        check("rst_t2_wr", WR, 1'b0);
        check("rst_t2_data", Data, 8'h77);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET     = 1'b0;
        tb_drive  = 1'b1;
        tb_val    = 8'($urandom);
        exp_rdata = 8'h00;
        exp_err   = 1'b0;
        @(negedge CLK);
        check_idle();
        @(posedge CLK);
        #1;
        do_txn(1'b0, 1'b1, 20'h0BEEF, 8'h00, 1, 8'h2D, 1'b0);

        // four queued writes with req_valid held high
        for (int i = 0; i < 4; i++) begin
            do_txn(1'b1, 1'($urandom), 20'($urandom), 8'($urandom), 0, 8'h00, (i < 3));
        end

        for (int i = 0; i < 40; i++) begin
            int w;
            if ($urandom_range(0, 3) == 0) w = $urandom_range(MAX_WAIT - 1, MAX_WAIT + 3);
            else                           w = $urandom_range(0, 5);
            do_txn(1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom), w,
                   8'($urandom), (i < 39) ? 1'($urandom) : 1'b0);
        end

        req_valid = 1'b0;
        tb_drive  = 1'b1;
        tb_val    = 8'($urandom);
        @(negedge CLK);
        check_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
